// File: rtl/awg_pkg.sv
// Shared types and limits for the AWG front-panel controller.
// Wave codes 0..4 follow the generator's case decode; 3'd7 is its OFF code.
package awg_pkg;

  typedef enum logic [1:0] {
    MENU_WAVE  = 2'd0,
    MENU_FREQ  = 2'd1,
    MENU_AMP   = 2'd2,
    MENU_PHASE = 2'd3
  } menu_e;

  localparam logic [2:0] WAVE_MAX  = 3'd4;
  localparam logic [3:0] FREQ_MIN  = 4'd1;
  localparam logic [3:0] FREQ_MAX  = 4'd6;
  localparam logic [3:0] AMP_MAX   = 4'd15;
  localparam logic [2:0] PHASE_MAX = 3'd7;
  localparam logic [2:0] STATE_OFF = 3'd7;

  function automatic menu_e next_menu(input menu_e cur);
    return menu_e'(cur + 2'd1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single push-button debouncer: 2-FF synchroniser, stability counter and a
// one-cycle press pulse that is only armed once the key has settled released.
module key_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int             CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          prev_r;
  logic          level_r;
  logic          armed_r;
  logic [CW-1:0] cnt_r;
  logic          stable_s;

  // A level is accepted only after the synced sample has held for the full window.
  assign stable_s = (sync2_r == prev_r) && (cnt_r == CNT_LAST);

  // Synchroniser, stability counter, accepted level and press arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      cnt_r   <= '0;
      level_r <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      sync1_r <= ~key_n;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      if (sync2_r != prev_r) begin
        cnt_r <= '0;
      end else if (cnt_r != CNT_LAST) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      if (stable_s) begin
        level_r <= sync2_r;
        armed_r <= armed_r | ~sync2_r;
      end else begin
        level_r <= level_r;
        armed_r <= armed_r;
      end
    end
  end

  // Key held through reset stays disarmed until it has settled released once.
  assign press = stable_s & sync2_r & ~level_r & armed_r;
  assign level = level_r;

endmodule

// File: rtl/awg_ctrl.sv
// Front-panel controller: four debounced keys drive a menu FSM that edits the
// wave/frequency/amplitude/phase settings feeding the waveform generator.
module awg_ctrl
  import awg_pkg::*;
#(
  parameter int         DEB_CYCLES = 1_000_000,
  parameter logic [3:0] AMP_RST    = 4'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode_n,
  input  logic        key_up_n,
  input  logic        key_down_n,
  input  logic        key_run_n,
  output logic [2:0]  state,
  output logic [11:0] state_freq,
  output logic [3:0]  state_amp,
  output logic [7:0]  state_phase,
  output logic [1:0]  menu_sel,
  output logic        running
);

  logic [3:0] key_level_unused_s;
  logic       p_mode_s, p_up_s, p_down_s, p_run_s;
  logic       edit_up_s, edit_dn_s;

  menu_e      menu_r,  menu_nxt_s;
  logic [2:0] wave_r,  wave_nxt_s;
  logic [3:0] freq_r,  freq_nxt_s;
  logic [3:0] amp_r,   amp_nxt_s;
  logic [2:0] phase_r, phase_nxt_s;
  logic       run_r,   run_nxt_s;
  logic [2:0] state_r;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk(clk), .rst_n(rst_n), .key_n(key_mode_n), .level(key_level_unused_s[0]), .press(p_mode_s));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst_n(rst_n), .key_n(key_up_n),   .level(key_level_unused_s[1]), .press(p_up_s));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk(clk), .rst_n(rst_n), .key_n(key_down_n), .level(key_level_unused_s[2]), .press(p_down_s));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk(clk), .rst_n(rst_n), .key_n(key_run_n),  .level(key_level_unused_s[3]), .press(p_run_s));

  // Edits cancel each other and yield to a menu move so they never hit the new field.
  assign edit_up_s = p_up_s & ~p_down_s & ~p_mode_s;
  assign edit_dn_s = p_down_s & ~p_up_s & ~p_mode_s;

  // Next-state for menu, settings and run flag.
  always_comb begin
    menu_nxt_s  = menu_r;
    wave_nxt_s  = wave_r;
    freq_nxt_s  = freq_r;
    amp_nxt_s   = amp_r;
    phase_nxt_s = phase_r;
    if (p_run_s) begin
      run_nxt_s = ~run_r;
    end else begin
      run_nxt_s = run_r;
    end
    if (p_mode_s) begin
      menu_nxt_s = next_menu(menu_r);
    end else if (edit_up_s || edit_dn_s) begin
      case (menu_r)
        MENU_WAVE: begin
          if (edit_up_s) begin
            wave_nxt_s = (wave_r >= WAVE_MAX) ? 3'd0 : wave_r + 3'd1;
          end else begin
            wave_nxt_s = (wave_r == 3'd0 || wave_r > WAVE_MAX) ? WAVE_MAX : wave_r - 3'd1;
          end
        end
        MENU_FREQ: begin
          if (edit_up_s) begin
            freq_nxt_s = (freq_r >= FREQ_MAX) ? FREQ_MAX : freq_r + 4'd1;
          end else begin
            freq_nxt_s = (freq_r <= FREQ_MIN) ? FREQ_MIN : freq_r - 4'd1;
          end
        end
        MENU_AMP: begin
          if (edit_up_s) begin
            amp_nxt_s = (amp_r == AMP_MAX) ? AMP_MAX : amp_r + 4'd1;
          end else begin
            amp_nxt_s = (amp_r == 4'd0) ? 4'd0 : amp_r - 4'd1;
          end
        end
        MENU_PHASE: begin
          if (edit_up_s) begin
            phase_nxt_s = (phase_r == PHASE_MAX) ? 3'd0 : phase_r + 3'd1;
          end else begin
            phase_nxt_s = (phase_r == 3'd0) ? PHASE_MAX : phase_r - 3'd1;
          end
        end
        default: begin
          menu_nxt_s = MENU_WAVE;
        end
      endcase
    end else begin
      menu_nxt_s = menu_r;
    end
  end

  // Setting and output registers; state carries the OFF code while stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      menu_r  <= MENU_WAVE;
      wave_r  <= 3'd0;
      freq_r  <= FREQ_MIN;
      amp_r   <= AMP_RST;
      phase_r <= 3'd0;
      run_r   <= 1'b0;
      state_r <= STATE_OFF;
    end else begin
      menu_r  <= menu_nxt_s;
      wave_r  <= wave_nxt_s;
      freq_r  <= freq_nxt_s;
      amp_r   <= amp_nxt_s;
      phase_r <= phase_nxt_s;
      run_r   <= run_nxt_s;
      state_r <= run_nxt_s ? wave_nxt_s : STATE_OFF;
    end
  end

  assign state       = state_r;
  assign state_freq  = {8'd0, freq_r};
  assign state_amp   = amp_r;
  assign state_phase = {5'd0, phase_r};
  assign menu_sel    = menu_r;
  assign running     = run_r;

endmodule

// File: tb/tb_awg_ctrl.sv
// Directed bench for awg_ctrl with a short debounce window; expected values are
// worked out by hand from the key sequence applied.
module tb_awg_ctrl;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  keys_n;   // [0]=mode [1]=up [2]=down [3]=run
  logic [2:0]  state;
  logic [11:0] state_freq;
  logic [3:0]  state_amp;
  logic [7:0]  state_phase;
  logic [1:0]  menu_sel;
  logic        running;

  int n_cmp = 0;
  int n_err = 0;

  awg_ctrl #(.DEB_CYCLES(DEB), .AMP_RST(4'd8)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_mode_n(keys_n[0]), .key_up_n(keys_n[1]),
    .key_down_n(keys_n[2]), .key_run_n(keys_n[3]),
    .state(state), .state_freq(state_freq), .state_amp(state_amp),
    .state_phase(state_phase), .menu_sel(menu_sel), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Press the keys in mask together, hold long enough to debounce, then release.
  task automatic tap(input logic [3:0] mask);
    keys_n = keys_n & ~mask;
    repeat (12) @(negedge clk);
    keys_n = keys_n | mask;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    keys_n = 4'hF;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);

    // 1: reset values
    chk("rst_state", state, 7);
    chk("rst_freq", state_freq, 1);
    chk("rst_amp", state_amp, 8);
    chk("rst_phase", state_phase, 0);
    chk("rst_menu", menu_sel, 0);
    chk("rst_running", running, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 2: run press latency and no auto-repeat
    keys_n[3] = 1'b0;
    repeat (DEB + 2) @(negedge clk);
    chk("run_early", running, 0);
    @(negedge clk);
    chk("run_on", running, 1);
    chk("run_state", state, 0);
    repeat (103) @(negedge clk);
    chk("run_held", running, 1);
    keys_n[3] = 1'b1;
    repeat (12) @(negedge clk);
    chk("run_release", running, 1);

    // 3: wave wrap, freq saturation
    for (int i = 1; i <= 5; i++) begin
      tap(4'b0010);
      chk($sformatf("wave_up%0d", i), state, i % 5);
    end
    tap(4'b0001);
    chk("menu_freq", menu_sel, 1);
    for (int i = 0; i < 3; i++) tap(4'b0100);
    chk("freq_sat_lo", state_freq, 1);
    for (int i = 0; i < 7; i++) tap(4'b0010);
    chk("freq_sat_hi", state_freq, 6);

    // 4: bounce then a clean hold gives one increment
    tap(4'b0001);
    chk("menu_amp", menu_sel, 2);
    for (int i = 0; i < 10; i++) begin
      keys_n[1] = ~keys_n[1];
      repeat (2) @(negedge clk);
    end
    chk("bounce_noinc", state_amp, 8);
    keys_n[1] = 1'b0;
    repeat (12) @(negedge clk);
    keys_n[1] = 1'b1;
    repeat (12) @(negedge clk);
    chk("bounce_one_inc", state_amp, 9);

    // 5: simultaneous pulses
    tap(4'b0100);
    chk("amp_down", state_amp, 8);
    tap(4'b0011);
    chk("sim_mode_menu", menu_sel, 3);
    chk("sim_mode_amp", state_amp, 8);
    chk("sim_mode_phase", state_phase, 0);
    tap(4'b0110);
    chk("sim_updn_phase", state_phase, 0);
    chk("sim_updn_menu", menu_sel, 3);
    tap(4'b0100);
    chk("phase_wrap", state_phase, 7);
    tap(4'b1000);
    chk("run_off", running, 0);
    chk("run_off_state", state, 7);

    // 6: reset mid-operation with up held
    for (int i = 0; i < 3; i++) tap(4'b0001);
    chk("menu_amp2", menu_sel, 2);
    for (int i = 0; i < 4; i++) tap(4'b0010);
    chk("amp_12", state_amp, 12);
    keys_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_amp", state_amp, 8);
    chk("mid_rst_menu", menu_sel, 0);
    chk("mid_rst_phase", state_phase, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("held_no_pulse_amp", state_amp, 8);
    tap(4'b1000);
    chk("held_no_inc_state", state, 0);
    keys_n[1] = 1'b1;
    repeat (12) @(negedge clk);
    chk("after_release_state", state, 0);
    tap(4'b0010);
    chk("repress_inc_state", state, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
